// File: rtl/decode_stage.sv
// RV32I-subset decode stage: combinational decode of the fetched word, registered
// into an output register backed by one skid entry so in_ready never depends on out_ready.
module decode_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [XLEN-1:0]   out_imm,
  output logic              out_alusrc,
  output logic [CTRL_W-1:0] out_aluctrl,
  output logic              out_memread,
  output logic              out_memwrite,
  output logic              out_regwrite,
  output logic              out_illegal,
  input  logic              flush,
  output logic [CNT_W-1:0]  cnt_illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [CTRL_W-1:0] ALU_ADD   = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] ALU_SUB   = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] ALU_AND   = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] ALU_OR    = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] ALU_XOR   = CTRL_W'(4);
  localparam logic [CTRL_W-1:0] ALU_SLL   = CTRL_W'(5);
  localparam logic [CTRL_W-1:0] ALU_SRL   = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] ALU_SRA   = CTRL_W'(7);
  localparam logic [CTRL_W-1:0] ALU_SLT   = CTRL_W'(8);
  localparam logic [CTRL_W-1:0] ALU_SLTU  = CTRL_W'(9);
  localparam logic [CTRL_W-1:0] ALU_PASSB = CTRL_W'(10);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic              alusrc;
    logic [CTRL_W-1:0] aluctrl;
    logic              memread;
    logic              memwrite;
    logic              regwrite;
    logic              illegal;
  } decT;

  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // alt selects SUB over ADD and SRA over SRL
  function automatic logic [CTRL_W-1:0] aluOp(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] immI, immS, immB, immU, immJ;

  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];
  assign immI   = {{20{in_inst[31]}}, in_inst[31:20]};
  assign immS   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign immB   = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign immU   = {in_inst[31:12], 12'b0};
  assign immJ   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  // ---- stage p0: combinational decode ----
  decT decData_p0;

  always_comb begin
    decData_p0     = '0;
    decData_p0.pc  = in_pc;
    decData_p0.rd  = in_inst[11:7];
    decData_p0.rs1 = in_inst[19:15];
    decData_p0.rs2 = in_inst[24:20];
    case (in_inst[6:0])
      OP_R: begin
        decData_p0.regwrite = 1'b1;
        decData_p0.aluctrl  = aluOp(funct3, funct7[5]);
        if (!((funct7 == 7'b0000000) ||
              ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))))
          decData_p0.illegal = 1'b1;
      end
      OP_IMM: begin
        decData_p0.alusrc   = 1'b1;
        decData_p0.regwrite = 1'b1;
        decData_p0.imm      = sext32(immI);
        decData_p0.aluctrl  = aluOp(funct3, (funct3 == 3'b101) && in_inst[30]);
      end
      OP_LOAD: begin
        decData_p0.alusrc   = 1'b1;
        decData_p0.regwrite = 1'b1;
        decData_p0.memread  = 1'b1;
        decData_p0.imm      = sext32(immI);
      end
      OP_STORE: begin
        decData_p0.alusrc   = 1'b1;
        decData_p0.memwrite = 1'b1;
        decData_p0.imm      = sext32(immS);
      end
      OP_BRANCH: begin
        decData_p0.aluctrl = ALU_SUB;
        decData_p0.imm     = sext32(immB);
      end
      OP_LUI: begin
        decData_p0.alusrc   = 1'b1;
        decData_p0.regwrite = 1'b1;
        decData_p0.aluctrl  = ALU_PASSB;
        decData_p0.imm      = sext32(immU);
      end
      OP_JAL: begin
        decData_p0.alusrc   = 1'b1;
        decData_p0.regwrite = 1'b1;
        decData_p0.imm      = sext32(immJ);
      end
      OP_JALR: begin
        decData_p0.alusrc   = 1'b1;
        decData_p0.regwrite = 1'b1;
        decData_p0.imm      = sext32(immI);
      end
      default: decData_p0.illegal = 1'b1;
    endcase
    if (decData_p0.illegal) begin
      decData_p0.regwrite = 1'b0;
      decData_p0.memread  = 1'b0;
      decData_p0.memwrite = 1'b0;
    end
  end

  // ---- stage p1: output register plus skid entry ----
  decT              outData_p1, skidData_p1;
  logic             vld_p1, skidVld_p1;
  logic [CNT_W-1:0] cntIllegal;
  logic             accept, issue;

  assign in_ready = !skidVld_p1 && !rst;
  assign accept   = in_valid && in_ready;
  assign issue    = vld_p1 && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      skidVld_p1  <= 1'b0;
      outData_p1  <= '0;
      skidData_p1 <= '0;
      cntIllegal  <= '0;
    end else begin
      if (issue && outData_p1.illegal)
        cntIllegal <= satInc(cntIllegal);
      if (flush) begin
        vld_p1     <= 1'b0;
        skidVld_p1 <= 1'b0;
      end else if (!vld_p1 || out_ready) begin
        // skid only fills while stalled, so it is drained before any new accept
        if (skidVld_p1) begin
          outData_p1 <= skidData_p1;
          vld_p1     <= 1'b1;
          skidVld_p1 <= 1'b0;
        end else begin
          vld_p1 <= accept;
          if (accept)
            outData_p1 <= decData_p0;
        end
      end else if (accept) begin
        skidData_p1 <= decData_p0;
        skidVld_p1  <= 1'b1;
      end
    end
  end

  assign out_valid    = vld_p1;
  assign out_pc       = outData_p1.pc;
  assign out_rd       = outData_p1.rd;
  assign out_rs1      = outData_p1.rs1;
  assign out_rs2      = outData_p1.rs2;
  assign out_imm      = outData_p1.imm;
  assign out_alusrc   = outData_p1.alusrc;
  assign out_aluctrl  = outData_p1.aluctrl;
  assign out_memread  = outData_p1.memread;
  assign out_memwrite = outData_p1.memwrite;
  assign out_regwrite = outData_p1.regwrite;
  assign out_illegal  = outData_p1.illegal;
  assign cnt_illegal  = cntIllegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode fields, skid/stall ordering, flush,
// saturating illegal counter (CNT_W = 2) and reset while buffered.
module tb_decode_stage;
  localparam int XLEN   = 32;
  localparam int CTRL_W = 4;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst, in_valid, in_ready, out_valid, out_ready, flush;
  logic [31:0]       in_inst;
  logic [XLEN-1:0]   in_pc, out_pc, out_imm;
  logic [4:0]        out_rd, out_rs1, out_rs2;
  logic              out_alusrc, out_memread, out_memwrite, out_regwrite, out_illegal;
  logic [CTRL_W-1:0] out_aluctrl;
  logic [CNT_W-1:0]  cnt_illegal;

  int checks = 0;
  int failures = 0;

  decode_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_alusrc(out_alusrc), .out_aluctrl(out_aluctrl),
    .out_memread(out_memread), .out_memwrite(out_memwrite),
    .out_regwrite(out_regwrite), .out_illegal(out_illegal),
    .flush(flush), .cnt_illegal(cnt_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int expCnt [5];
    expCnt = '{0, 1, 2, 3, 3};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    in_inst = 32'h0; in_pc = '0;

    // reset state
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cnt", cnt_illegal, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rd", out_rd, 0);
    chk("rst_imm", out_imm, 0);
    rst = 1'b0; #1;
    chk("post_rst_in_ready", in_ready, 1);

    // addi x5,x0,-1
    in_valid = 1'b1; in_inst = 32'hFFF00293; in_pc = 32'h100;
    tick(); in_valid = 1'b0;
    chk("addi_valid", out_valid, 1);
    chk("addi_rd", out_rd, 5);
    chk("addi_rs1", out_rs1, 0);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_alusrc", out_alusrc, 1);
    chk("addi_aluctrl", out_aluctrl, 0);
    chk("addi_regwrite", out_regwrite, 1);
    chk("addi_illegal", out_illegal, 0);
    chk("addi_pc", out_pc, 32'h100);

    // sw x6,8(x2)
    in_valid = 1'b1; in_inst = 32'h00612423; in_pc = 32'h104;
    tick(); in_valid = 1'b0;
    chk("sw_rs1", out_rs1, 2);
    chk("sw_rs2", out_rs2, 6);
    chk("sw_imm", out_imm, 8);
    chk("sw_memwrite", out_memwrite, 1);
    chk("sw_regwrite", out_regwrite, 0);
    chk("sw_memread", out_memread, 0);
    tick();
    chk("drain_valid", out_valid, 0);

    // stall: add x1,x2,x3 then sub x4,x5,x6 into skid
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h003100B3; in_pc = 32'h200;
    tick();
    chk("stall_a_valid", out_valid, 1);
    chk("stall_a_pc", out_pc, 32'h200);
    chk("stall_a_in_ready", in_ready, 1);
    in_inst = 32'h40628233; in_pc = 32'h204;
    tick(); in_valid = 1'b0;
    chk("stall_skid_in_ready", in_ready, 0);
    chk("stall_hold_pc", out_pc, 32'h200);
    chk("stall_hold_aluctrl", out_aluctrl, 0);
    tick();
    chk("stall_hold2_pc", out_pc, 32'h200);
    chk("stall_hold2_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    chk("release_b_valid", out_valid, 1);
    chk("release_b_pc", out_pc, 32'h204);
    chk("release_b_aluctrl", out_aluctrl, 1);
    chk("release_in_ready", in_ready, 1);
    tick();
    chk("release_empty", out_valid, 0);

    // flush with both entries full and a third offered
    out_ready = 1'b0; in_valid = 1'b1;
    in_inst = 32'hFFF00293; in_pc = 32'h300;
    tick();
    in_pc = 32'h304;
    tick();
    chk("flush_pre_in_ready", in_ready, 0);
    in_pc = 32'h308; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_no_issue", out_valid, 0);
    end
    // flush discards the instruction accepted in the same cycle
    in_valid = 1'b1; in_pc = 32'h30C; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_accept_discard", out_valid, 0);

    // saturating illegal counter, five illegal words back to back
    in_valid = 1'b1; in_inst = 32'hFFFFFFFF;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 4) in_valid = 1'b0;
      chk("ill_flag", out_illegal, 1);
      chk("ill_we", {out_regwrite, out_memread, out_memwrite}, 0);
      chk("ill_cnt", cnt_illegal, expCnt[k]);
    end
    tick();
    chk("ill_cnt_sat", cnt_illegal, 3);
    chk("ill_drained", out_valid, 0);

    // lui, beq, mul (illegal funct7)
    in_valid = 1'b1; in_inst = 32'h123453B7;
    tick();
    chk("lui_imm", out_imm, 32'h12345000);
    chk("lui_aluctrl", out_aluctrl, 10);
    chk("lui_rd", out_rd, 7);
    in_inst = 32'hFE208EE3;
    tick();
    chk("beq_imm", out_imm, 32'hFFFFFFFC);
    chk("beq_aluctrl", out_aluctrl, 1);
    chk("beq_alusrc", out_alusrc, 0);
    chk("beq_regwrite", out_regwrite, 0);
    in_inst = 32'h023100B3;
    tick(); in_valid = 1'b0;
    chk("mul_illegal", out_illegal, 1);
    chk("mul_regwrite", out_regwrite, 0);

    // reset with skid full
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h003100B3;
    tick(); tick();
    chk("rstmid_pre_in_ready", in_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; #1;
    chk("rstmid_valid", out_valid, 0);
    chk("rstmid_cnt", cnt_illegal, 0);
    chk("rstmid_in_ready", in_ready, 1);
    out_ready = 1'b1;
    tick();
    chk("rstmid_no_issue", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter CTRL_W, default 4, width of out_aluctrl.
REQ-003 Parameter CNT_W, default 16, width of the illegal-instruction counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  / in_ready  output  1  / in_inst  input  32  / in_pc  input  XLEN: fetch-side handshake.
REQ-007 out_valid  output  1  / out_ready  input  1  / out_pc  output  XLEN: execute-side handshake.
REQ-008 out_rd, out_rs1, out_rs2  output  5 each  register addresses.
REQ-009 out_imm  output  XLEN  sign-extended immediate.
REQ-010 out_alusrc  output  1  ALU operand B select: 1 = imm, 0 = rs2.
REQ-011 out_aluctrl  output  CTRL_W  ALU operation.
REQ-012 out_memread, out_memwrite, out_regwrite, out_illegal  output  1 each.
REQ-013 flush  input  1  discard all buffered instructions.
REQ-014 cnt_illegal  output  CNT_W  saturating count of illegal instructions issued.

Function
REQ-015 Opcodes decoded: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, JAL 1101111, JALR 1100111; any other opcode is illegal.
REQ-016 Immediate formats I/S/B/U/J per RV32I, sign-extended from bit 31 to XLEN; R-type imm = 0.
REQ-017 aluctrl encoding: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, PASSB 10; LOAD/STORE/JALR/JAL use ADD, BRANCH uses SUB, LUI uses PASSB.
REQ-018 alusrc = 1 for I-ALU, LOAD, STORE, LUI, JAL, JALR; 0 otherwise.
REQ-019 regwrite = 1 for R, I-ALU, LOAD, LUI, JAL, JALR; memread = 1 only for LOAD; memwrite = 1 only for STORE.
REQ-020 R-type with funct7 not in {0000000, 0100000}, or with 0100000 on a funct3 other than ADD/SUB or SRL/SRA, is illegal.
REQ-021 Illegal instruction: out_illegal = 1; regwrite, memread and memwrite forced to 0; the instruction still flows through the handshake.
REQ-022 Storage: one output register plus one skid entry; decode is combinational on in_inst, and the results are registered.
REQ-023 Latency: an accepted instruction appears at the outputs on the first edge after acceptance when the output register is empty or is draining.
REQ-024 Accept = in_valid & in_ready; issue = out_valid & out_ready.
REQ-025 in_ready = !skid_valid & !rst, driven from a register (no combinational path from out_ready).
REQ-026 Output stalled (out_valid & !out_ready) and accept: the new instruction goes to the skid entry.
REQ-027 Skid entry full and issue: the skid entry moves to the output register on the same edge.
REQ-028 Outputs are held stable while out_valid & !out_ready.
REQ-029 Order is strictly FIFO; no instruction is lost or duplicated.
REQ-030 flush = 1: on the next edge, both entries are invalidated and the instruction accepted that cycle is discarded.
REQ-031 During flush, cnt_illegal does not count discarded instructions.
REQ-032 cnt_illegal increments on each issue with out_illegal = 1, and saturates at all-ones.
REQ-033 Decode fields are don't-care when out_valid = 0, but they never produce X.

Reset
REQ-034 While rst = 1 at an edge: out_valid = 0, skid_valid = 0, cnt_illegal = 0, all decode outputs = 0.
REQ-035 in_ready = 0 while rst = 1, and = 1 in the first cycle after rst deasserts.
REQ-036 Reset asserted mid-stall drops both buffered instructions; rst has priority over flush and in_valid.

Verification
REQ-037 addi x5,x0,-1 (0xFFF00293), out_ready = 1 -> next cycle: out_valid = 1, rd = 5, rs1 = 0, imm = 0xFFFFFFFF, alusrc = 1, aluctrl = 0, regwrite = 1, illegal = 0.
REQ-038 sw x6,8(x2) (0x00612423) -> rs1 = 2, rs2 = 6, imm = 8, memwrite = 1, regwrite = 0, memread = 0.
REQ-039 out_ready = 0 while two instructions are offered -> second instruction held in skid, in_ready = 0 the next cycle; release out_ready -> both issue in order on consecutive cycles.
REQ-040 Both entries full, in_valid = 1, flush pulse -> next cycle: out_valid = 0, in_ready = 1, none of the three instructions ever issues.
REQ-041 CNT_W = 2, five issues of 0xFFFFFFFF -> out_illegal = 1 each time, all write enables 0, cnt_illegal = 1, 2, 3, 3, 3.
REQ-042 rst pulsed with the skid entry full -> following cycle: out_valid = 0, cnt_illegal = 0, in_ready = 1.
